multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore-style FSM that sequences a shared-memory multicycle RV32I datapath (PC, IR, OldPC, ALUOut, Data regs).
//  Decodes op/funct fields and drives every datapath mux select and write strobe, one micro-step per clock.
//  Stalls on a memory ready handshake. Flags unsupported encodings.
// PARAMETERS
//  none. All encodings are fixed constants in define.v.
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  op           in   7  IR[6:0]
//  funct3       in   3  IR[14:12]
//  funct7_5     in   1  IR[30]
//  zero         in   1  ALU zero flag (combinational, current cycle)
//  mem_ready    in   1  memory has completed the current read/write this cycle
//  pc_write     out  1  PC <= Result
//  adr_src      out  1  memory address: 0=PC, 1=Result
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  IR <= RD and OldPC <= PC
//  reg_write    out  1  rd <= Result
//  result_src   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  alu_src_a    out  2  00=PC, 01=OldPC, 10=rs1
//  alu_src_b    out  2  00=rs2, 01=imm, 10=const 4
//  imm_src      out  3  000=I, 001=S, 010=B, 011=J
//  alu_control  out  3  000=add, 001=sub, 010=and, 011=or, 101=slt
//  illegal      out  1  high while in TRAP
// BEHAVIOUR
//  - rst=1: state <= FETCH at the next edge.
//    While rst is high, pc_write, ir_write, mem_read, mem_write and reg_write are forced to 0, illegal=0, and all selects are 0.
//    Asserting rst in any state, including a pending MEMWRITE, abandons the operation.
//  - States and transitions:
//    FETCH: mem_read=1, adr_src=0, A=00, B=10, add, result_src=10.
//      ir_write and pc_write assert only in the cycle mem_ready=1; then go to DECODE. Otherwise stay.
//    DECODE: A=01, B=01, imm_src=010, add (ALUOut <= OldPC + B-imm).
//      Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI;
//      1100011 -> BRANCH; 1101111 -> JAL; anything else, or an unsupported funct3, -> TRAP.
//    MEMADR: A=10, B=01, add. imm_src=000 for lw, 001 for sw.
//      Go to MEMREAD if op[5]=0, otherwise to MEMWRITE.
//    MEMREAD: mem_read=1, adr_src=1, result_src=00. Hold until mem_ready, then go to MEMWB.
//    MEMWB: result_src=01, reg_write=1, then go to FETCH.
//    MEMWRITE: mem_write=1, adr_src=1, result_src=00. Hold until mem_ready, then go to FETCH.
//    EXECR: A=10, B=00, funct-decoded op, then go to ALUWB.
//    EXECI: A=10, B=01, imm_src=000, funct-decoded op, then go to ALUWB.
//    ALUWB: result_src=00, reg_write=1, then go to FETCH.
//    BRANCH: A=10, B=00, sub, result_src=00.
//      pc_write = (funct3==000 & zero) | (funct3==001 & ~zero). Then go to FETCH.
//    JAL: A=01, B=10, add, result_src=00, pc_write=1, then go to ALUWB (rd <= OldPC+4).
//    TRAP: illegal=1 and all strobes 0. Stays in TRAP until rst.
//  - Funct decode, used for EXECR and EXECI only:
//    000: sub if (funct7_5 & op[5]), else add. 010: slt. 110: or. 111: and.
//    Any other funct3 -> TRAP from DECODE. funct3 other than 000/001 on a branch -> TRAP.
//  - Selects are don't-care when unlisted and are driven 0. Outputs are combinational from state,
//    mem_ready, zero, op and funct fields. No output registers.
//  - Latency with mem_ready tied to 1: lw 5 cycles; sw, R, I and jal 4 cycles; branch 3 cycles.
//    Each memory-ready wait adds 1 cycle.
// CONFIGURATION
//  MCTRL_JALR_EN defined: op 1100111 with funct3=000 -> JALR1.
//    JALR1: A=10, B=01, imm_src=000, add (ALUOut <= rs1+imm), then go to JAL.
//    JAL then writes PC <= ALUOut and rd <= OldPC+4. jalr takes 5 cycles.
//  MCTRL_JALR_EN undefined: op 1100111 -> TRAP.
// STRUCTURE
//  define.v holds the state encodings (4-bit localparams), opcode constants, and the ALU, result, src and imm encodings.
//  One sub-module: mc_alu_decode (combinational). Inputs: alu_op[1:0] (00 add, 01 sub, 10 funct), funct3, funct7_5, op5.
//    Outputs: alu_control and funct_bad.
//  The top level holds the state register, next-state logic and output decode.
// TESTING
//  - Reset: hold rst for 2 cycles in the middle of MEMWRITE with mem_ready=0.
//    -> mem_write=0 during reset; state is FETCH with mem_read=1 the cycle after.
//  - add x3,x1,x2 (0x002081B3), mem_ready=1.
//    -> FETCH, DECODE, EXECR (alu_control=000), ALUWB (reg_write=1); 4 cycles total.
//  - lw (0x0000A183) with mem_ready low for 3 cycles in MEMREAD.
//    -> MEMREAD held 4 cycles; reg_write=1 with result_src=01 exactly once; 8 cycles total.
//  - beq with zero=1, then beq with zero=0; bne with zero=0.
//    -> pc_write=1, 0 and 1 respectively in BRANCH, with alu_control=001.
//  - sub (funct7_5=1, op=0110011) -> alu_control=001.
//    addi with IR[30]=1 -> alu_control=000 (add, not sub).
//  - op=1100111 -> with MCTRL_JALR_EN: JALR1, JAL (pc_write=1), ALUWB.
//    Without MCTRL_JALR_EN: illegal=1 held until rst.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg
// Shared constants for the multicycle RV32I controller: FSM state
// encodings (4-bit), opcode values, ALU control codes, ALU-op classes
// and the encodings of the result/source/immediate select fields.
// Optional build macro used by importers: MCTRL_JALR_EN (adds JALR1).
`timescale 1ns/1ps
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11,
        S_JALR1    = 4'd12
    } state_t;

    // Opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct3 values with special meaning to the sequencer
    localparam logic [2:0] F3_WORD = 3'b010;   // lw / sw
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // result_src
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // alu_src_a
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // imm_src
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/multicycle_controller_alu_decode.sv
// mc_alu_decode
// Combinational ALU control decoder.
// Ports:
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct fields
//   funct3      in  3  IR[14:12]
//   funct7_5    in  1  IR[30]
//   op5         in  1  IR[5] (distinguishes R-type from I-type)
//   alu_control out 3  ALU operation code
//   funct_bad   out 1  funct3 is not one of the implemented ALU ops
// funct_bad depends on funct3 only, so the sequencer can test it in
// DECODE while the ALU itself is still doing a plain add.
`timescale 1ns/1ps
module mc_alu_decode
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic       funct_bad
);

    logic [2:0] funct_control;

    always_comb begin
        funct_control = ALU_ADD;
        funct_bad     = 1'b0;
        case (funct3)
            // IR[30] selects sub only for R-type; for addi it is an imm bit
            3'b000:  funct_control = (funct7_5 & op5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_control = ALU_SLT;
            3'b110:  funct_control = ALU_OR;
            3'b111:  funct_control = ALU_AND;
            default: funct_bad     = 1'b1;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_control;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore-style sequencer for a shared-memory multicycle RV32I datapath.
// One micro-step per clock; memory steps stall on mem_ready; unsupported
// encodings park the FSM in TRAP until reset.
// Optional feature macro: MCTRL_JALR_EN (jalr via JALR1 -> JAL -> ALUWB;
// without it opcode 1100111 traps).
// Ports:
//   clk, rst (sync, active high)
//   op[6:0], funct3[2:0], funct7_5, zero, mem_ready        inputs
//   pc_write, adr_src, mem_read, mem_write, ir_write,
//   reg_write, result_src[1:0], alu_src_a[1:0],
//   alu_src_b[1:0], imm_src[2:0], alu_control[2:0], illegal outputs
`timescale 1ns/1ps
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal
);

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       funct_bad;

    mc_alu_decode u_alu_decode (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .op5         (op[5]),
        .alu_control (alu_control),
        .funct_bad   (funct_bad)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    // only word-sized memory accesses are implemented
                    OP_LOAD, OP_STORE:
                        state_next = (funct3 == F3_WORD) ? S_MEMADR : S_TRAP;
                    OP_RTYPE:  state_next = funct_bad ? S_TRAP : S_EXECR;
                    OP_ITYPE:  state_next = funct_bad ? S_TRAP : S_EXECI;
                    OP_BRANCH:
                        state_next = (funct3 == F3_BEQ || funct3 == F3_BNE)
                                     ? S_BRANCH : S_TRAP;
                    OP_JAL:    state_next = S_JAL;
`ifdef MCTRL_JALR_EN
                    OP_JALR:
                        state_next = (funct3 == F3_JALR) ? S_JALR1 : S_TRAP;
`endif
                    default:   state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            // JAL's ALUOut holds OldPC+4 for the link write in ALUWB
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
`ifdef MCTRL_JALR_EN
            S_JALR1:    state_next = S_JAL;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode; reset masks everything so an abandoned access
    // cannot leave a strobe asserted.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_B;
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = op[5] ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    mem_read = 1'b1;
                    adr_src  = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_SUB;
                    pc_write  = ((funct3 == F3_BEQ) &  zero) |
                                ((funct3 == F3_BNE) & ~zero);
                end
                S_JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
`ifdef MCTRL_JALR_EN
                S_JALR1: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                end
`endif
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed bench for multicycle_controller. All outputs are packed into
// one 19-bit control word and compared against hand-built expectations
// each cycle. Honours MCTRL_JALR_EN for the jalr section.
`timescale 1ns/1ps
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;
    logic       illegal;

    int compared   = 0;
    int mismatched = 0;
    int rw_seen    = 0;

    multicycle_controller dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    logic [18:0] ctl;
    assign ctl = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};

    function automatic logic [18:0] mk(
        input logic pcw, input logic adr, input logic mr, input logic mw,
        input logic irw, input logic rw, input logic [1:0] rs,
        input logic [1:0] a, input logic [1:0] b, input logic [2:0] imm,
        input logic [2:0] alu, input logic ill);
        return {pcw, adr, mr, mw, irw, rw, rs, a, b, imm, alu, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 with inputs already set; compares the control
    // word, then advances one clock.
    task automatic step(input string tag, input logic [18:0] exp);
        #1;
        check(tag, {13'd0, ctl}, {13'd0, exp});
        if (reg_write) rw_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [31:0] ir);
        op       = ir[6:0];
        funct3   = ir[14:12];
        funct7_5 = ir[30];
    endtask

    logic [18:0] v_zero, v_fetch_rdy, v_fetch_wait, v_decode, v_memadr_lw,
                 v_memadr_sw, v_memread, v_memwb, v_memwrite, v_aluwb, v_jal, v_trap;
    int rw_base;

    function automatic logic [18:0] v_execr(input logic [2:0] alu);
        return mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0);
    endfunction
    function automatic logic [18:0] v_execi(input logic [2:0] alu);
        return mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 0);
    endfunction
    function automatic logic [18:0] v_branch(input logic pcw);
        return mk(pcw,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0);
    endfunction

    initial begin
        v_zero       = '0;
        v_fetch_rdy  = mk(1,0,1,0,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
        v_fetch_wait = mk(0,0,1,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
        v_decode     = mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 0);
        v_memadr_lw  = mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
        v_memadr_sw  = mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0);
        v_memread    = mk(0,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
        v_memwb      = mk(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0);
        v_memwrite   = mk(0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
        v_aluwb      = mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
        v_jal        = mk(1,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0);
        v_trap       = mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1);

        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        set_ir(32'h0020A023);
        @(posedge clk); #1;
        step("reset_outputs", v_zero);
        rst = 1'b0;

        // sw, abandoned by reset while MEMWRITE waits
        mem_ready = 1'b1;
        step("sw_fetch", v_fetch_rdy);
        step("sw_decode", v_decode);
        step("sw_memadr", v_memadr_sw);
        mem_ready = 1'b0;
        step("sw_memwrite_wait0", v_memwrite);
        step("sw_memwrite_wait1", v_memwrite);
        rst = 1'b1;
        step("rst_in_memwrite0", v_zero);
        step("rst_in_memwrite1", v_zero);
        rst = 1'b0;
        step("fetch_after_rst", v_fetch_wait);
        $display("txn sw+reset: checked");

        // add x3,x1,x2
        mem_ready = 1'b1;
        set_ir(32'h002081B3);
        step("add_fetch", v_fetch_rdy);
        step("add_decode", v_decode);
        step("add_execr", v_execr(3'b000));
        step("add_aluwb", v_aluwb);
        $display("txn add: checked");

        // lw with three wait cycles in MEMREAD
        set_ir(32'h0000A183);
        step("add_next_fetch", v_fetch_rdy);
        rw_base = rw_seen;
        step("lw_decode", v_decode);
        step("lw_memadr", v_memadr_lw);
        mem_ready = 1'b0;
        step("lw_memread_w0", v_memread);
        step("lw_memread_w1", v_memread);
        step("lw_memread_w2", v_memread);
        mem_ready = 1'b1;
        step("lw_memread_rdy", v_memread);
        step("lw_memwb", v_memwb);
        check("lw_regwrite_count", rw_seen - rw_base, 1);
        $display("txn lw: checked");

        // beq taken
        set_ir(32'h00208063);
        step("lw_next_fetch", v_fetch_rdy);
        step("beq1_decode", v_decode);
        zero = 1'b1;
        step("beq_zero1", v_branch(1'b1));
        $display("txn beq zero=1: checked");
        // beq not taken
        step("beq2_fetch", v_fetch_rdy);
        step("beq2_decode", v_decode);
        zero = 1'b0;
        step("beq_zero0", v_branch(1'b0));
        $display("txn beq zero=0: checked");
        // bne taken
        set_ir(32'h00209063);
        step("bne_fetch", v_fetch_rdy);
        step("bne_decode", v_decode);
        zero = 1'b0;
        step("bne_zero0", v_branch(1'b1));
        $display("txn bne zero=0: checked");

        // sub x3,x1,x2
        set_ir(32'h402081B3);
        step("sub_fetch", v_fetch_rdy);
        step("sub_decode", v_decode);
        step("sub_execr", v_execr(3'b001));
        step("sub_aluwb", v_aluwb);
        $display("txn sub: checked");

        // addi x3,x1,0x400 (IR[30]=1 must not turn it into sub)
        set_ir(32'h40008193);
        step("addi_fetch", v_fetch_rdy);
        step("addi_decode", v_decode);
        step("addi_execi", v_execi(3'b000));
        step("addi_aluwb", v_aluwb);
        $display("txn addi: checked");

        // slti and or/and decode
        set_ir(32'h0020A193);
        step("slti_fetch", v_fetch_rdy);
        step("slti_decode", v_decode);
        step("slti_execi", v_execi(3'b101));
        step("slti_aluwb", v_aluwb);
        set_ir(32'h0020E1B3);
        step("or_fetch", v_fetch_rdy);
        step("or_decode", v_decode);
        step("or_execr", v_execr(3'b011));
        step("or_aluwb", v_aluwb);
        set_ir(32'h0020F1B3);
        step("and_fetch", v_fetch_rdy);
        step("and_decode", v_decode);
        step("and_execr", v_execr(3'b010));
        step("and_aluwb", v_aluwb);
        $display("txn slti/or/and: checked");

        // jal x1,8
        set_ir(32'h008000EF);
        step("jal_fetch", v_fetch_rdy);
        step("jal_decode", v_decode);
        step("jal_jal", v_jal);
        step("jal_aluwb", v_aluwb);
        $display("txn jal: checked");

        // jalr x1,0(x2)
        set_ir(32'h000100E7);
        step("jalr_fetch", v_fetch_rdy);
        step("jalr_decode", v_decode);
`ifdef MCTRL_JALR_EN
        step("jalr_jalr1", v_memadr_lw);
        step("jalr_jal", v_jal);
        step("jalr_aluwb", v_aluwb);
`else
        zero = 1'b1;
        step("jalr_trap0", v_trap);
        step("jalr_trap1", v_trap);
        step("jalr_trap2", v_trap);
        rst = 1'b1;
        step("jalr_trap_rst", v_zero);
        rst = 1'b0;
        zero = 1'b0;
`endif
        $display("txn jalr: checked");

        // sll (unimplemented funct3) traps until reset
        set_ir(32'h002091B3);
        step("sll_fetch", v_fetch_rdy);
        step("sll_decode", v_decode);
        step("sll_trap0", v_trap);
        step("sll_trap1", v_trap);
        rst = 1'b1;
        step("sll_trap_rst", v_zero);
        rst = 1'b0;
        step("sll_after_rst_fetch", v_fetch_rdy);
        $display("txn sll trap: checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
